// File: rtl/can_rx_fifo_filter_if.sv
// Frame-receive and head-of-queue signals shared between a CAN RX filter/FIFO
// and the logic around it. The master side drives received frames and pops
// the head; the slave side is the filter/FIFO itself.
interface can_rx_fifo_filter_if #(
  parameter int DEPTH_LOG2 = 3
);
  logic                  rx_valid;
  logic [28:0]           rx_id;
  logic                  rx_ide;
  logic                  rx_rtr;
  logic [3:0]            rx_len;
  logic [63:0]           rx_data;
  logic                  rx_ack;
  logic                  flush;
  logic                  m_valid;
  logic                  m_ready;
  logic [28:0]           m_id;
  logic                  m_ide;
  logic                  m_rtr;
  logic [3:0]            m_len;
  logic [63:0]           m_data;
  logic [DEPTH_LOG2:0]   level;
  logic [15:0]           ovf_cnt;

  modport master (
    output rx_valid, rx_id, rx_ide, rx_rtr, rx_len, rx_data, flush, m_ready,
    input  rx_ack, m_valid, m_id, m_ide, m_rtr, m_len, m_data, level, ovf_cnt
  );

  modport slave (
    input  rx_valid, rx_id, rx_ide, rx_rtr, rx_len, rx_data, flush, m_ready,
    output rx_ack, m_valid, m_id, m_ide, m_rtr, m_len, m_data, level, ovf_cnt
  );
endinterface

// File: rtl/can_rx_fifo_filter.sv
// CAN receive acceptance filter feeding a first-word-fall-through frame FIFO.
// Matching frames are stored; matching frames that find the FIFO full are
// counted as overflows; non-matching frames are dropped silently. rx_ack
// tells the packet stage whether the last frame was taken.
// The interface instance must be built with the same DEPTH_LOG2 as this block.
module can_rx_fifo_filter #(
  parameter int          DEPTH_LOG2  = 3,
  parameter logic [28:0] ACCEPT_ID   = 29'h0,
  parameter logic [28:0] ACCEPT_MASK = 29'h0,
  parameter logic [0:0]  IDE_CARE    = 1'b0,
  parameter logic [0:0]  ACCEPT_IDE  = 1'b0
) (
  input  logic                 clk,
  input  logic                 rstn,
  can_rx_fifo_filter_if.slave  bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int FW    = 29 + 1 + 1 + 4 + 64;
  // Level value meaning "full"; one bit wider than the pointers.
  localparam logic [DEPTH_LOG2:0] LEVEL_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [FW-1:0]         mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   level_q;
  logic [15:0]           ovf_q;
  logic                  ack_q;

  logic match;
  logic full;
  logic do_wr;
  logic do_drop;
  logic do_pop;
  logic [FW-1:0] head;

  // Acceptance filter and the per-cycle write/drop/pop decisions.
  // Full is judged on the pre-edge level, so a same-cycle pop never makes room.
  always_comb begin
    match   = (((bus.rx_id ^ ACCEPT_ID) & ACCEPT_MASK) == 29'h0) &&
              ((IDE_CARE == 1'b0) || (bus.rx_ide == ACCEPT_IDE));
    full    = (level_q == LEVEL_FULL);
    do_wr   = bus.rx_valid && !bus.flush && match && !full;
    do_drop = bus.rx_valid && !bus.flush && match && full;
    do_pop  = !bus.flush && (level_q != '0) && bus.m_ready;
  end

  // Frame storage; contents are qualified by level so no reset is needed.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= {bus.rx_id, bus.rx_ide, bus.rx_rtr, bus.rx_len, bus.rx_data};
    end
  end

  // Pointers, occupancy, ACK register and saturating overflow counter.
  // Flush clears the queue and ACK but deliberately keeps the overflow history.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      ack_q   <= 1'b0;
      ovf_q   <= 16'h0;
    end else if (bus.flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      ack_q   <= 1'b0;
    end else begin
      if (bus.rx_valid) ack_q <= do_wr;
      if (do_wr)  wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      if (do_wr && !do_pop)      level_q <= level_q + 1'b1;
      else if (!do_wr && do_pop) level_q <= level_q - 1'b1;
      if (do_drop && (ovf_q != 16'hFFFF)) ovf_q <= ovf_q + 1'b1;
    end
  end

  assign head        = mem[rd_ptr];
  assign bus.m_id    = head[FW-1 -: 29];
  assign bus.m_ide   = head[69];
  assign bus.m_rtr   = head[68];
  assign bus.m_len   = head[67:64];
  assign bus.m_data  = head[63:0];
  assign bus.m_valid = (level_q != '0);
  assign bus.level   = level_q;
  assign bus.ovf_cnt = ovf_q;
  assign bus.rx_ack  = ack_q;

endmodule

// File: tb/tb_can_rx_fifo_filter.sv
// Directed bench for can_rx_fifo_filter. Instance A uses default parameters
// (depth 8, accept-all); instance B is depth 4 with an 11-bit ID filter on
// 0x456 and IDE required to be 1. sel routes the shared stimulus to one of them.
module tb_can_rx_fifo_filter;

  logic clk;
  logic rstn;
  logic sel;

  logic        drv_valid;
  logic [28:0] drv_id;
  logic        drv_ide;
  logic        drv_rtr;
  logic [3:0]  drv_len;
  logic [63:0] drv_data;
  logic        drv_flush;
  logic        drv_ready;

  int checks;
  int failures;

  logic [28:0] q[$];

  can_rx_fifo_filter_if #(.DEPTH_LOG2(3)) ifa ();
  can_rx_fifo_filter_if #(.DEPTH_LOG2(2)) ifb ();

  can_rx_fifo_filter u_dut_a (
    .clk  (clk),
    .rstn (rstn),
    .bus  (ifa.slave)
  );

  can_rx_fifo_filter #(
    .DEPTH_LOG2  (2),
    .ACCEPT_ID   (29'h456),
    .ACCEPT_MASK (29'h7FF),
    .IDE_CARE    (1'b1),
    .ACCEPT_IDE  (1'b1)
  ) u_dut_b (
    .clk  (clk),
    .rstn (rstn),
    .bus  (ifb.slave)
  );

  assign ifa.rx_valid = drv_valid & ~sel;
  assign ifa.flush    = drv_flush & ~sel;
  assign ifa.m_ready  = drv_ready & ~sel;
  assign ifa.rx_id    = drv_id;
  assign ifa.rx_ide   = drv_ide;
  assign ifa.rx_rtr   = drv_rtr;
  assign ifa.rx_len   = drv_len;
  assign ifa.rx_data  = drv_data;

  assign ifb.rx_valid = drv_valid & sel;
  assign ifb.flush    = drv_flush & sel;
  assign ifb.m_ready  = drv_ready & sel;
  assign ifb.rx_id    = drv_id;
  assign ifb.rx_ide   = drv_ide;
  assign ifb.rx_rtr   = drv_rtr;
  assign ifb.rx_len   = drv_len;
  assign ifb.rx_data  = drv_data;

  logic        obs_ack, obs_valid, obs_rtr, obs_ide;
  logic [28:0] obs_id;
  logic [3:0]  obs_len, obs_level;
  logic [63:0] obs_data;
  logic [15:0] obs_ovf;

  assign obs_ack   = sel ? ifb.rx_ack  : ifa.rx_ack;
  assign obs_valid = sel ? ifb.m_valid : ifa.m_valid;
  assign obs_rtr   = sel ? ifb.m_rtr   : ifa.m_rtr;
  assign obs_ide   = sel ? ifb.m_ide   : ifa.m_ide;
  assign obs_id    = sel ? ifb.m_id    : ifa.m_id;
  assign obs_len   = sel ? ifb.m_len   : ifa.m_len;
  assign obs_data  = sel ? ifb.m_data  : ifa.m_data;
  assign obs_ovf   = sel ? ifb.ovf_cnt : ifa.ovf_cnt;
  assign obs_level = sel ? 4'(ifb.level) : 4'(ifa.level);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] data_of(input logic [28:0] id);
    return {3'b000, id, 16'hC0DE, id[15:0]};
  endfunction

  function automatic logic [28:0] idk(input int k);
    return 29'h456 | 29'(k << 12);
  endfunction

  // Compare occupancy and head of instance B against the expected queue.
  task automatic check_head(input string tag);
    check_val({tag, "_level"}, 64'(obs_level), 64'(q.size()));
    check_val({tag, "_mvalid"}, 64'(obs_valid), 64'(q.size() != 0));
    if (q.size() != 0) begin
      check_val({tag, "_mid"}, 64'(obs_id), 64'(q[0]));
      check_val({tag, "_mdata"}, obs_data, data_of(q[0]));
    end
  endtask

  task automatic push_b(input logic [28:0] id, input logic ide, input logic pop,
                        input logic exp_ack, input string tag);
    drv_id    = id;
    drv_ide   = ide;
    drv_rtr   = 1'b0;
    drv_len   = 4'd8;
    drv_data  = data_of(id);
    drv_valid = 1'b1;
    drv_ready = pop;
    if (pop && q.size() != 0) q.delete(0);
    if (exp_ack) q.push_back(id);
    step();
    drv_valid = 1'b0;
    drv_ready = 1'b0;
    check_val({tag, "_ack"}, 64'(obs_ack), 64'(exp_ack));
    check_head(tag);
  endtask

  task automatic pop_b(input string tag);
    drv_ready = 1'b1;
    if (q.size() != 0) q.delete(0);
    step();
    drv_ready = 1'b0;
    check_head(tag);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    sel       = 1'b0;
    rstn      = 1'b0;
    drv_valid = 1'b0;
    drv_id    = '0;
    drv_ide   = 1'b0;
    drv_rtr   = 1'b0;
    drv_len   = '0;
    drv_data  = '0;
    drv_flush = 1'b0;
    drv_ready = 1'b0;

    #12;
    check_val("rst_ack", 64'(obs_ack), 0);
    check_val("rst_level", 64'(obs_level), 0);
    check_val("rst_mvalid", 64'(obs_valid), 0);
    check_val("rst_ovf", 64'(obs_ovf), 0);
    @(posedge clk);
    #1 rstn = 1'b1;

    // Instance A: accept-all, single frame through and out.
    drv_id    = 29'h123;
    drv_ide   = 1'b0;
    drv_rtr   = 1'b1;
    drv_len   = 4'd4;
    drv_data  = 64'hDEADBEEF;
    drv_valid = 1'b1;
    step();
    drv_valid = 1'b0;
    check_val("a_ack", 64'(obs_ack), 1);
    check_val("a_mvalid", 64'(obs_valid), 1);
    check_val("a_level", 64'(obs_level), 1);
    check_val("a_mid", 64'(obs_id), 64'h123);
    check_val("a_mlen", 64'(obs_len), 4);
    check_val("a_mrtr", 64'(obs_rtr), 1);
    check_val("a_mide", 64'(obs_ide), 0);
    check_val("a_mdata", obs_data, 64'hDEADBEEF);
    drv_ready = 1'b1;
    step();
    drv_ready = 1'b0;
    check_val("a_pop_level", 64'(obs_level), 0);
    check_val("a_pop_mvalid", 64'(obs_valid), 0);
    check_val("a_ack_held", 64'(obs_ack), 1);

    // Instance B: filter behaviour.
    sel = 1'b1;
    q.delete();
    push_b(29'h456, 1'b1, 1'b0, 1'b1, "b_hit");
    push_b(29'h457, 1'b1, 1'b0, 1'b0, "b_miss");
    check_val("b_miss_ovf", 64'(obs_ovf), 0);
    push_b(29'h456, 1'b0, 1'b0, 1'b0, "b_ide_miss");
    push_b(29'h1ABC456, 1'b1, 1'b0, 1'b1, "b_upper_dc");
    pop_b("b_pop0");
    pop_b("b_pop1");
    pop_b("b_pop_empty");
    check_val("b_filter_ovf", 64'(obs_ovf), 0);

    // Fill depth-4 FIFO, fifth frame overflows.
    for (int k = 0; k < 4; k++) push_b(idk(k), 1'b1, 1'b0, 1'b1, "b_fill");
    push_b(idk(4), 1'b1, 1'b0, 1'b0, "b_full");
    check_val("b_full_ovf", 64'(obs_ovf), 1);
    check_val("b_full_level", 64'(obs_level), 4);

    // Full with same-cycle pop: pop wins, incoming frame dropped.
    push_b(idk(5), 1'b1, 1'b1, 1'b0, "b_full_pop");
    check_val("b_full_pop_ovf", 64'(obs_ovf), 2);
    check_val("b_full_pop_head", 64'(obs_id), 64'(idk(1)));

    // Write/pop pairs at level 3, wrapping both pointers.
    for (int k = 6; k < 12; k++) push_b(idk(k), 1'b1, 1'b1, 1'b1, "b_pair");
    for (int k = 0; k < 3; k++) pop_b("b_drain");
    check_val("b_drain_ovf", 64'(obs_ovf), 2);

    // Flush at level 3 together with a matching frame and m_ready.
    for (int k = 20; k < 23; k++) push_b(idk(k), 1'b1, 1'b0, 1'b1, "b_pre_flush");
    drv_id    = idk(23);
    drv_ide   = 1'b1;
    drv_data  = data_of(idk(23));
    drv_valid = 1'b1;
    drv_flush = 1'b1;
    drv_ready = 1'b1;
    step();
    drv_valid = 1'b0;
    drv_flush = 1'b0;
    drv_ready = 1'b0;
    q.delete();
    check_val("b_flush_ack", 64'(obs_ack), 0);
    check_val("b_flush_ovf", 64'(obs_ovf), 2);
    check_head("b_flush");
    push_b(idk(24), 1'b1, 1'b0, 1'b1, "b_post_flush");
    pop_b("b_post_flush_pop");

    // Build level 2 / ovf 5, then reset mid-stream.
    for (int k = 25; k < 29; k++) push_b(idk(k), 1'b1, 1'b0, 1'b1, "b_refill");
    for (int k = 29; k < 32; k++) push_b(idk(k), 1'b1, 1'b0, 1'b0, "b_reovf");
    check_val("b_reovf_ovf", 64'(obs_ovf), 5);
    for (int k = 0; k < 3; k++) pop_b("b_repop");
    push_b(idk(32), 1'b1, 1'b0, 1'b1, "b_pre_rst");
    check_val("b_pre_rst_ovf", 64'(obs_ovf), 5);
    #2 rstn = 1'b0;
    #1;
    q.delete();
    check_val("b_mrst_ack", 64'(obs_ack), 0);
    check_val("b_mrst_level", 64'(obs_level), 0);
    check_val("b_mrst_mvalid", 64'(obs_valid), 0);
    check_val("b_mrst_ovf", 64'(obs_ovf), 0);
    @(posedge clk);
    #1 rstn = 1'b1;
    push_b(idk(33), 1'b1, 1'b0, 1'b1, "b_post_rst");
    check_val("b_post_rst_ovf", 64'(obs_ovf), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/can_rx_fifo_filter.md
CAN_RX_FIFO_FILTER -- requirements
Module: can_rx_fifo_filter

Interface
REQ-001 The block SHALL have parameter DEPTH_LOG2, default 3, giving FIFO depth DEPTH = 2**DEPTH_LOG2 frames (legal range 1..6).
REQ-002 The block SHALL have parameter ACCEPT_ID [28:0], default 29'h0, the acceptance code.
REQ-003 The block SHALL have parameter ACCEPT_MASK [28:0], default 29'h0, where 1 means the ID bit is compared and 0 means accept-all.
REQ-004 The block SHALL have parameter IDE_CARE [0:0], default 1'b0, where 1 means rx_ide must equal ACCEPT_IDE.
REQ-005 The block SHALL have parameter ACCEPT_IDE [0:0], default 1'b0, the required IDE value when IDE_CARE=1.
REQ-006 The block SHALL have port rstn, input, 1 bit: asynchronous active-low reset; 1 = working.
REQ-007 The block SHALL have port clk, input, 1 bit: system clock; this is the only clock.
REQ-008 The block SHALL have port rx_valid, input, 1 bit: one-cycle pulse meaning a CRC-good frame is present on rx_id..rx_data.
REQ-009 The block SHALL have ports rx_id (input, 29 bits), rx_ide (input, 1 bit), rx_rtr (input, 1 bit), rx_len (input, 4 bits) and rx_data (input, 64 bits): the received frame fields, valid only while rx_valid=1.
REQ-010 The block SHALL have port rx_ack, output, 1 bit: ACK permission to the packet stage, sampled by it one cycle after rx_valid.
REQ-011 The block SHALL have port flush, input, 1 bit: synchronous FIFO clear.
REQ-012 The block SHALL have port m_valid, output, 1 bit: a frame is available at the head.
REQ-013 The block SHALL have port m_ready, input, 1 bit: the consumer accepts the head frame.
REQ-014 The block SHALL have ports m_id (output, 29 bits), m_ide (output, 1 bit), m_rtr (output, 1 bit), m_len (output, 4 bits) and m_data (output, 64 bits): the head frame fields.
REQ-015 The block SHALL have port level, output, DEPTH_LOG2+1 bits: the number of stored frames.
REQ-016 The block SHALL have port ovf_cnt, output, 16 bits: the count of accepted-but-dropped frames.

Function
REQ-017 The block SHALL compute match = (((rx_id ^ ACCEPT_ID) & ACCEPT_MASK) == 0) && (!IDE_CARE || rx_ide == ACCEPT_IDE), combinationally.
REQ-018 The block SHALL define full as level == DEPTH, evaluated from the pre-edge level; a pop in the same cycle does not free space for a write.
REQ-019 On a cycle with rx_valid=1, flush=0, match=1 and full=0, the block SHALL write {id,ide,rtr,len,data} at the write pointer and register rx_ack <= 1.
REQ-020 On a cycle with rx_valid=1, flush=0, match=1 and full=1, the block SHALL not write the frame, SHALL register rx_ack <= 0, and SHALL increment ovf_cnt, saturating at 16'hFFFF.
REQ-021 On a cycle with rx_valid=1 and match=0, the block SHALL discard the frame silently, register rx_ack <= 0, and leave ovf_cnt unchanged.
REQ-022 The block SHALL hold rx_ack at its registered value until the next rx_valid or flush, so the packet stage sees a stable value one cycle after rx_valid.
REQ-023 The block SHALL store rx_data unmodified, with payload bytes right-aligned in the low bits; the block SHALL NOT re-align by rx_len.
REQ-024 The block SHALL implement first-word-fall-through: m_valid = (level != 0), and m_* show the entry at the read pointer combinationally from the storage.
REQ-025 A written frame SHALL appear on m_valid in the cycle after the rx_valid pulse, giving a write-to-visible latency of 1 clock.
REQ-026 On a cycle with m_valid=1 and m_ready=1, the block SHALL pop the head: the read pointer advances by 1.
REQ-027 When m_valid=0, m_ready SHALL be ignored; popping an empty FIFO SHALL NOT change any state.
REQ-028 The read and write pointers SHALL be DEPTH_LOG2 bits wide and wrap modulo DEPTH.
REQ-029 level SHALL change by +1 on a write only, by -1 on a pop only, and remain unchanged when a write and a pop occur in the same cycle.
REQ-030 A simultaneous write and pop when level=DEPTH-1 or lower SHALL both succeed.
REQ-031 A simultaneous rx_valid and pop when level=DEPTH SHALL pop, drop the incoming frame as an overflow, and leave level at DEPTH-1.
REQ-032 flush=1 SHALL set both pointers and level to 0 and rx_ack <= 0.
REQ-033 On a flush cycle, any rx_valid frame SHALL be discarded without incrementing ovf_cnt, and m_ready SHALL be ignored.
REQ-034 flush SHALL NOT clear ovf_cnt.
REQ-035 m_* data outputs SHALL be don't-care while m_valid=0.

Reset
REQ-036 On rstn=0, asynchronously, the block SHALL set rx_ack=0, level=0, m_valid=0, ovf_cnt=0 and both pointers=0.
REQ-037 Storage contents SHALL need no reset.
REQ-038 On deassertion of rstn, the block SHALL behave as empty, with the first rx_valid accepted on the first working edge.
REQ-039 A reset mid-operation SHALL discard all stored frames; no partial frame SHALL survive it.

Verification
REQ-040 Scenario: defaults (mask 0); rx_valid with id=29'h123, len=4, data=64'hDEADBEEF -> rx_ack=1 next cycle; m_valid=1 next cycle with same fields; m_ready=1 -> level 0.
REQ-041 Scenario: ACCEPT_ID=29'h456, ACCEPT_MASK=29'h7FF; frames id=29'h456 then 29'h457 -> first stored with rx_ack=1; second gives rx_ack=0, level=1, ovf_cnt=0.
REQ-042 Scenario: DEPTH_LOG2=2, m_ready=0; 5 matching frames -> level=4, rx_ack 1,1,1,1,0, ovf_cnt=1; draining returns frames 1-4 in order.
REQ-043 Scenario: DEPTH_LOG2=2, full FIFO; rx_valid and pop in same cycle -> level=3, ovf_cnt+1, head advances; then 6 write/pop pairs exercise pointer wrap with data order preserved.
REQ-044 Scenario: level=3; flush together with rx_valid -> level=0, m_valid=0, rx_ack=0, ovf_cnt unchanged.
REQ-045 Scenario: rstn pulsed low mid-stream with level=2 and ovf_cnt=5 -> all outputs at reset values immediately; next frame accepted normally.
